// File: rtl/sdm_adc_frame_defs_pkg.sv
// Frame layout constants shared by the SDM/ADC aggregator and deframer.
// Nine 64-bit words carry a 510-bit payload; word 8 is the trailer.
package sdm_adc_frame_defs;

   localparam int FRAME_WORDS  = 9;
   localparam int DATA_BITS    = 63;
   localparam int TAIL_BITS    = 6;
   localparam int PAYLOAD_BITS = 510;

   // The 60-bit literal is narrowed to the 57-bit field it occupies.
   localparam logic [59:0] MAGIC_RAW = 60'hb72ea61d950c840;
   localparam logic [56:0] MAGIC     = MAGIC_RAW[56:0];

   localparam logic [0:0] ST_HUNT    = 1'b0;
   localparam logic [0:0] ST_COLLECT = 1'b1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/sdm_adc_frame_deframer_classifier.sv
// Combinational decode of one received word into data / trailer /
// bad-flag classes (exactly one is high for every word).
module frame_word_classifier
   import sdm_adc_frame_defs::*;
#(
   parameter logic [56:0] MAGIC_P = MAGIC
) (
   input  logic [63:0] din,
   output logic        is_data,
   output logic        is_trailer,
   output logic        is_bad_flag
);

   logic magic_ok;

   always_comb begin
      magic_ok    = (din[62:6] == MAGIC_P);
      is_data     = ~din[63];
      is_trailer  = din[63] & magic_ok;
      is_bad_flag = din[63] & ~magic_ok;
   end

endmodule

// File: rtl/sdm_adc_frame_deframer.sv
// Locks onto the 9-word trailer-delimited stream and rebuilds the
// 510-bit payload; reports lock, emitted-frame and framing-error counts.
module sdm_adc_frame_deframer
   import sdm_adc_frame_defs::*;
#(
   parameter int          FRAME_WORDS = 9,
   parameter logic [56:0] MAGIC       = sdm_adc_frame_defs::MAGIC,
   parameter int          LOCK_FRAMES = 2
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [63:0]  DIN,
   input  logic         DIN_VALID,
   output logic [511:0] DOUT,
   output logic         DOUT_VALID,
   output logic         SYNCED,
   output logic [31:0]  FRAME_CNT,
   output logic [15:0]  ERR_CNT
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_WORDS - 1);
   localparam logic [3:0] LOCK_Q   = 4'(LOCK_FRAMES);

   logic                    is_data;
   logic                    is_trailer;
   logic                    is_bad_flag;

   logic [0:0]              state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic [3:0]              good_run_q, good_run_d;
   logic [PAYLOAD_BITS-1:0] buf_q, buf_d;
   logic [511:0]            dout_q, dout_d;
   logic                    dout_valid_q, dout_valid_d;
   logic                    synced_q, synced_d;
   logic [31:0]             frame_cnt_q, frame_cnt_d;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic                    good_frame;
   logic                    frame_err;

   frame_word_classifier #(
      .MAGIC_P(MAGIC)
   ) u_classifier (
      .din        (DIN),
      .is_data    (is_data),
      .is_trailer (is_trailer),
      .is_bad_flag(is_bad_flag)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      good_run_d   = good_run_q;
      buf_d        = buf_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      err_cnt_d    = err_cnt_q;
      good_frame   = 1'b0;
      frame_err    = 1'b0;

      if (DIN_VALID) begin
         case (state_q)
            ST_HUNT: begin
               if (is_trailer) begin
                  state_d = ST_COLLECT;
                  idx_d   = 4'd0;
               end
            end
            default: begin
               if (idx_q != LAST_IDX) begin
                  unique case (1'b1)
                     is_data: begin
                        // Only the addressed 63-bit slice is written.
                        for (int k = 0; k < FRAME_WORDS - 1; k++) begin
                           if (idx_q == 4'(k)) begin
                              buf_d[DATA_BITS*k +: DATA_BITS] = DIN[62:0];
                           end
                        end
                        idx_d = idx_q + 4'd1;
                     end
                     is_trailer: begin
                        // Short frame: realign on this trailer.
                        frame_err  = 1'b1;
                        idx_d      = 4'd0;
                        good_run_d = 4'd0;
                     end
                     is_bad_flag: begin
                        frame_err  = 1'b1;
                        state_d    = ST_HUNT;
                        idx_d      = 4'd0;
                        good_run_d = 4'd0;
                     end
                     default: ;
                  endcase
               end else if (is_trailer) begin
                  good_frame = 1'b1;
                  buf_d[PAYLOAD_BITS-1 -: TAIL_BITS] = DIN[TAIL_BITS-1:0];
                  idx_d      = 4'd0;
                  good_run_d = sat_inc4(good_run_q);
               end else begin
                  frame_err  = 1'b1;
                  state_d    = ST_HUNT;
                  idx_d      = 4'd0;
                  good_run_d = 4'd0;
               end
            end
         endcase
      end

      if (good_frame && (good_run_d >= LOCK_Q)) begin
         dout_d       = {2'b00, DIN[TAIL_BITS-1:0],
                         buf_q[PAYLOAD_BITS-TAIL_BITS-1:0]};
         dout_valid_d = 1'b1;
         frame_cnt_d  = frame_cnt_q + 32'd1;
      end

      if (frame_err) begin
         err_cnt_d = sat_inc16(err_cnt_q);
      end

      synced_d = (good_run_d >= LOCK_Q);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_HUNT;
         idx_q        <= 4'd0;
         good_run_q   <= 4'd0;
         buf_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         synced_q     <= 1'b0;
         frame_cnt_q  <= 32'd0;
         err_cnt_q    <= 16'd0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         good_run_q   <= good_run_d;
         buf_q        <= buf_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         synced_q     <= synced_d;
         frame_cnt_q  <= frame_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign DOUT       = dout_q;
   assign DOUT_VALID = dout_valid_q;
   assign SYNCED     = synced_q;
   assign FRAME_CNT  = frame_cnt_q;
   assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_sdm_adc_frame_deframer.sv
// Directed bench for sdm_adc_frame_deframer with an emission scoreboard.
module tb_sdm_adc_frame_deframer;

   localparam logic [59:0] MAGIC_RAW = 60'hb72ea61d950c840;
   localparam logic [56:0] MAGIC     = MAGIC_RAW[56:0];

   logic         CLK;
   logic         RESET;
   logic [63:0]  DIN;
   logic         DIN_VALID;
   logic [511:0] DOUT;
   logic         DOUT_VALID;
   logic         SYNCED;
   logic [31:0]  FRAME_CNT;
   logic [15:0]  ERR_CNT;

   typedef struct {
      logic [509:0] pay;
      int           cyc;
   } exp_t;

   exp_t sbq[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   n_valid    = 0;
   int   cyc        = 0;

   sdm_adc_frame_deframer #(
      .FRAME_WORDS(9),
      .MAGIC      (MAGIC),
      .LOCK_FRAMES(2)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .DIN       (DIN),
      .DIN_VALID (DIN_VALID),
      .DOUT      (DOUT),
      .DOUT_VALID(DOUT_VALID),
      .SYNCED    (SYNCED),
      .FRAME_CNT (FRAME_CNT),
      .ERR_CNT   (ERR_CNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mkword(input logic [509:0] p,
                                          input int k);
      if (k < 8) return {1'b0, p[63*k +: 63]};
      return {1'b1, MAGIC, p[509:504]};
   endfunction

   function automatic logic [509:0] rnd_pay();
      logic [509:0] p;
      for (int j = 0; j < 510; j++) p[j] = 1'($urandom_range(1));
      return p;
   endfunction

   task automatic idle();
      @(negedge CLK);
      DIN_VALID = 1'b0;
      // Invalid cycles carry junk, sometimes trailer-shaped.
      if ($urandom_range(1) == 1) DIN = {1'b1, MAGIC, 6'h2a};
      else DIN = {$urandom, $urandom};
   endtask

   task automatic send(input logic [509:0] p, input bit emit,
                       input int first, input int last, input bit gaps);
      for (int k = first; k <= last; k++) begin
         if (gaps) while ($urandom_range(1) == 0) idle();
         @(negedge CLK);
         DIN       = mkword(p, k);
         DIN_VALID = 1'b1;
         if (k == 8 && emit) sbq.push_back('{p, cyc + 1});
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET     = 1'b1;
      DIN_VALID = 1'b0;
      sbq.delete();
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic settle();
      idle();
      idle();
      chk("scoreboard_drained", 512'(sbq.size()), 512'(0));
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (DOUT_VALID === 1'b1) begin
            n_valid++;
            if (sbq.size() == 0) begin
               chk("spurious_valid", 512'(DOUT_VALID), 512'(0));
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("dout", DOUT, {2'b00, e.pay});
               chk("latency", 512'(cyc), 512'(e.cyc));
            end
         end
      end
   end

   logic [509:0] pat, p3, px;
   int           nv0;

   initial begin
      RESET     = 1'b1;
      DIN       = '0;
      DIN_VALID = 1'b0;
      for (int i = 0; i < 510; i++) pat[i] = i[0] ^ i[3];
      repeat (3) @(negedge CLK);

      chk("rst_dout", DOUT, 512'(0));
      chk("rst_valid", 512'(DOUT_VALID), 512'(0));
      chk("rst_synced", 512'(SYNCED), 512'(0));
      chk("rst_frame_cnt", 512'(FRAME_CNT), 512'(0));
      chk("rst_err_cnt", 512'(ERR_CNT), 512'(0));
      RESET = 1'b0;

      // Clean start: frame 1 acquires, frame 2 counts, frame 3 emits.
      send(pat, 0, 0, 8, 0);
      send(pat, 0, 0, 8, 0);
      settle();
      chk("t1_synced_pre", 512'(SYNCED), 512'(0));
      chk("t1_cnt_pre", 512'(FRAME_CNT), 512'(0));
      send(pat, 1, 0, 8, 0);
      px = rnd_pay();
      send(px, 1, 0, 8, 0);
      settle();
      chk("t1_synced", 512'(SYNCED), 512'(1));
      chk("t1_frame_cnt", 512'(FRAME_CNT), 512'(2));
      chk("t1_err_cnt", 512'(ERR_CNT), 512'(0));
      chk("t1_dout_hold", DOUT, {2'b00, px});

      // Mid-frame start.
      do_reset();
      px = rnd_pay();
      send(px, 0, 4, 8, 0);
      send(pat, 0, 0, 8, 0);
      px = rnd_pay();
      send(px, 1, 0, 8, 0);
      settle();
      chk("t2_frame_cnt", 512'(FRAME_CNT), 512'(1));
      chk("t2_err_cnt", 512'(ERR_CNT), 512'(0));

      // Short frame while locked: trailer at idx 5.
      px = rnd_pay();
      send(px, 1, 0, 8, 0);
      px = rnd_pay();
      send(px, 0, 0, 4, 0);
      send(px, 0, 8, 8, 0);
      settle();
      chk("t3_err_cnt", 512'(ERR_CNT), 512'(1));
      chk("t3_synced", 512'(SYNCED), 512'(0));
      send(rnd_pay(), 0, 0, 8, 0);
      px = rnd_pay();
      send(px, 1, 0, 8, 0);
      settle();
      chk("t3_relock", 512'(SYNCED), 512'(1));
      chk("t3_err_after", 512'(ERR_CNT), 512'(1));
      chk("t3_frame_cnt", 512'(FRAME_CNT), 512'(3));

      // Corrupted magic on the trailer of a locked stream.
      do_reset();
      send(rnd_pay(), 0, 0, 8, 0);
      send(rnd_pay(), 0, 0, 8, 0);
      p3 = rnd_pay();
      send(p3, 1, 0, 8, 0);
      px = rnd_pay();
      send(px, 0, 0, 7, 0);
      @(negedge CLK);
      DIN       = mkword(px, 8) ^ (64'd1 << 36);
      DIN_VALID = 1'b1;
      settle();
      chk("t4_err_cnt", 512'(ERR_CNT), 512'(1));
      chk("t4_synced", 512'(SYNCED), 512'(0));
      chk("t4_dout_kept", DOUT, {2'b00, p3});
      chk("t4_frame_cnt", 512'(FRAME_CNT), 512'(1));
      send(rnd_pay(), 0, 0, 8, 0);
      send(rnd_pay(), 0, 0, 8, 0);
      send(rnd_pay(), 1, 0, 8, 0);
      settle();
      chk("t4_rehunt_cnt", 512'(FRAME_CNT), 512'(2));

      // 100 frames with random valid gaps.
      do_reset();
      nv0 = n_valid;
      for (int f = 0; f < 100; f++) send(rnd_pay(), f >= 2, 0, 8, 1);
      settle();
      chk("t5_emissions", 512'(n_valid - nv0), 512'(98));
      chk("t5_frame_cnt", 512'(FRAME_CNT), 512'(98));
      chk("t5_err_cnt", 512'(ERR_CNT), 512'(0));

      // Asynchronous reset at idx 4 of a locked stream.
      chk("t6_synced_pre", 512'(SYNCED), 512'(1));
      send(rnd_pay(), 0, 0, 3, 0);
      @(posedge CLK);
      #2;
      RESET     = 1'b1;
      DIN_VALID = 1'b0;
      #1;
      chk("t6_dout", DOUT, 512'(0));
      chk("t6_valid", 512'(DOUT_VALID), 512'(0));
      chk("t6_synced", 512'(SYNCED), 512'(0));
      chk("t6_frame_cnt", 512'(FRAME_CNT), 512'(0));
      chk("t6_err_cnt", 512'(ERR_CNT), 512'(0));
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      send(rnd_pay(), 0, 0, 8, 0);
      send(rnd_pay(), 0, 0, 8, 0);
      settle();
      chk("t6_unlocked", 512'(SYNCED), 512'(0));
      send(rnd_pay(), 1, 0, 8, 0);
      settle();
      chk("t6_relock", 512'(SYNCED), 512'(1));
      chk("t6_frame_cnt2", 512'(FRAME_CNT), 512'(1));

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
